// File: rtl/sram_rw_arbiter_if.sv
// Client- and SRAM-facing bus of the buffer SRAM arbiter.
// The slave modport is the arbiter's view; master is the view of the
// requesters and the SRAM macro taken together.
interface sram_rw_arbiter_if #(
  parameter int ADDR_W  = 12,
  parameter int WDATA_W = 160,
  parameter int RDATA_W = 192
);
  // write requester (loader)
  logic               wr_valid;
  logic               wr_ready;
  logic [ADDR_W-1:0]  wr_addr;
  logic [WDATA_W-1:0] wr_data;

  // read requester 0 (compute-array fetch)
  logic               rd0_valid;
  logic               rd0_ready;
  logic [ADDR_W-1:0]  rd0_addr;
  logic               rd0_resp_valid;
  logic [RDATA_W-1:0] rd0_resp_data;

  // read requester 1 (result unload)
  logic               rd1_valid;
  logic               rd1_ready;
  logic [ADDR_W-1:0]  rd1_addr;
  logic               rd1_resp_valid;
  logic [RDATA_W-1:0] rd1_resp_data;

  // SRAM macro pins
  logic               sram_wsbn;
  logic [ADDR_W-1:0]  sram_waddr;
  logic [WDATA_W-1:0] sram_wdata;
  logic               sram_csbn;
  logic [ADDR_W-1:0]  sram_raddr;
  logic [RDATA_W-1:0] sram_rdata;

  modport slave (
    input  wr_valid, wr_addr, wr_data,
    input  rd0_valid, rd0_addr,
    input  rd1_valid, rd1_addr,
    input  sram_rdata,
    output wr_ready,
    output rd0_ready, rd0_resp_valid, rd0_resp_data,
    output rd1_ready, rd1_resp_valid, rd1_resp_data,
    output sram_wsbn, sram_waddr, sram_wdata,
    output sram_csbn, sram_raddr
  );

  modport master (
    output wr_valid, wr_addr, wr_data,
    output rd0_valid, rd0_addr,
    output rd1_valid, rd1_addr,
    output sram_rdata,
    input  wr_ready,
    input  rd0_ready, rd0_resp_valid, rd0_resp_data,
    input  rd1_ready, rd1_resp_valid, rd1_resp_data,
    input  sram_wsbn, sram_waddr, sram_wdata,
    input  sram_csbn, sram_raddr
  );
endinterface

// File: rtl/sram_rw_arbiter.sv
// sram_rw_arbiter: one write port and two round-robin read ports in front of
// the 4096 x 192 buffer SRAM. One write and one read per cycle, read data
// returned one cycle after the grant with a per-reader strobe.
// Optional feature macro: SRAM_ARB_RAW_BYPASS_EN -- when defined, a read that
// hits the address being written in the same cycle is granted and answered
// from a forwarding register; when undefined such a read is stalled a cycle.
module sram_rw_arbiter #(
  parameter int ADDR_W  = 12,
  parameter int WDATA_W = 160,
  parameter int RDATA_W = 192
) (
  input  logic             clk,
  input  logic             rst,
  sram_rw_arbiter_if.slave bus
);

  localparam int PAD_W = RDATA_W - WDATA_W;
  localparam int NRD   = 2;

  // per-reader views of the request/response signals
  logic [NRD-1:0]     rd_valid;
  logic [ADDR_W-1:0]  rd_addr [NRD];
  logic [NRD-1:0]     rd_ready;
  logic [NRD-1:0]     rd_resp_valid;
  logic [RDATA_W-1:0] rd_resp_data;

  // write accept and read arbitration
  logic               wr_acc;
  logic               cand_valid;
  logic               cand_id;
  logic [ADDR_W-1:0]  cand_addr;
  logic               raw_hazard;
  logic               rd_grant;

  // state
  logic               rr_last_q, rr_last_d;
  logic               resp_v_q, resp_v_d;
  logic               resp_id_q, resp_id_d;
  logic [ADDR_W-1:0]  waddr_q, waddr_d;
  logic [WDATA_W-1:0] wdata_q, wdata_d;
  logic [ADDR_W-1:0]  raddr_q, raddr_d;

  assign rd_valid   = {bus.rd1_valid, bus.rd0_valid};
  assign rd_addr[0] = bus.rd0_addr;
  assign rd_addr[1] = bus.rd1_addr;

  // The write side never stalls: every valid write outside reset is taken.
  assign wr_acc = bus.wr_valid && !rst;

  // Pick the read candidate: a lone requester wins, otherwise whoever did not win last.
  always_comb begin
    cand_id = 1'b0;
    case (rd_valid)
      2'b01:   cand_id = 1'b0;
      2'b10:   cand_id = 1'b1;
      2'b11:   cand_id = ~rr_last_q;
      default: cand_id = 1'b0;
    endcase
    cand_valid = (|rd_valid) && !rst;
    cand_addr  = rd_addr[cand_id];
  end

  // A read colliding with this cycle's write would see the old word in the SRAM.
  always_comb begin
    raw_hazard = wr_acc && cand_valid && (cand_addr == bus.wr_addr);
`ifdef SRAM_ARB_RAW_BYPASS_EN
    rd_grant   = cand_valid;
`else
    // Stall the whole read slot; the loser is not promoted in its place.
    rd_grant   = cand_valid && !raw_hazard;
`endif
  end

  genvar gi;
  generate
    for (gi = 0; gi < NRD; gi++) begin : g_rd
      assign rd_ready[gi]      = rd_grant && (cand_id == 1'(gi));
      assign rd_resp_valid[gi] = resp_v_q && (resp_id_q == 1'(gi));
    end
  endgenerate

  // SRAM pin values; addresses and data hold their last value when not used.
  always_comb begin
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    raddr_d = raddr_q;
    if (rst) begin
      waddr_d = '0;
      wdata_d = '0;
      raddr_d = '0;
    end else begin
      if (wr_acc) begin
        waddr_d = bus.wr_addr;
        wdata_d = bus.wr_data;
      end
      if (rd_grant) begin
        raddr_d = cand_addr;
      end
    end
  end

  // Next state for the round-robin pointer and the response tag.
  always_comb begin
    rr_last_d = rr_last_q;
    if (rd_grant) begin
      rr_last_d = cand_id;
    end
    resp_v_d  = rd_grant;
    resp_id_d = rd_grant ? cand_id : resp_id_q;
  end

  // Arbiter and response-pipeline registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_last_q <= 1'b1;
      resp_v_q  <= 1'b0;
      resp_id_q <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      raddr_q   <= '0;
    end else begin
      rr_last_q <= rr_last_d;
      resp_v_q  <= resp_v_d;
      resp_id_q <= resp_id_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      raddr_q   <= raddr_d;
    end
  end

`ifdef SRAM_ARB_RAW_BYPASS_EN
  logic               resp_byp_q, resp_byp_d;
  logic [RDATA_W-1:0] byp_data_q, byp_data_d;

  // Capture the word being written when a colliding read is granted.
  always_comb begin
    resp_byp_d = rd_grant && raw_hazard;
    byp_data_d = byp_data_q;
    if (resp_byp_d) begin
      byp_data_d = {{PAD_W{1'b0}}, bus.wr_data};
    end
  end

  // Forwarding registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_byp_q <= 1'b0;
      byp_data_q <= '0;
    end else begin
      resp_byp_q <= resp_byp_d;
      byp_data_q <= byp_data_d;
    end
  end

  assign rd_resp_data = resp_byp_q ? byp_data_q : bus.sram_rdata;
`else
  assign rd_resp_data = bus.sram_rdata;
`endif

  // Outputs. A write cycle must also pull csbn low for the macro to write.
  assign bus.wr_ready       = !rst;
  assign bus.rd0_ready      = rd_ready[0];
  assign bus.rd1_ready      = rd_ready[1];
  assign bus.rd0_resp_valid = rd_resp_valid[0];
  assign bus.rd1_resp_valid = rd_resp_valid[1];
  assign bus.rd0_resp_data  = rd_resp_data;
  assign bus.rd1_resp_data  = rd_resp_data;
  assign bus.sram_wsbn      = !wr_acc;
  assign bus.sram_csbn      = !(wr_acc || rd_grant);
  assign bus.sram_waddr     = waddr_d;
  assign bus.sram_wdata     = wdata_d;
  assign bus.sram_raddr     = raddr_d;

endmodule

// File: tb/tb_sram_rw_arbiter.sv
// Directed bench for sram_rw_arbiter with a behavioural SRAM model.
module tb_sram_rw_arbiter;
  localparam int ADDR_W  = 12;
  localparam int WDATA_W = 160;
  localparam int RDATA_W = 192;

  localparam logic [RDATA_W-1:0] P0  = {6{32'h0123_4567}};
  localparam logic [RDATA_W-1:0] P1  = {6{32'h89AB_CDEF}};
  localparam logic [WDATA_W-1:0] WA5 = {20{8'hA5}};
  localparam logic [WDATA_W-1:0] WD  = {5{32'hDEAD_BEEF}};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sram_rw_arbiter_if #(.ADDR_W(ADDR_W), .WDATA_W(WDATA_W), .RDATA_W(RDATA_W)) bus ();

  sram_rw_arbiter #(.ADDR_W(ADDR_W), .WDATA_W(WDATA_W), .RDATA_W(RDATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // SRAM model: write-through-csbn/wsbn, registered read, output held when idle
  logic [RDATA_W-1:0] mem [4096];
  logic [RDATA_W-1:0] sram_rdata_q;
  always @(posedge clk) begin
    if (rst) begin
      mem[12'h010] <= P0;
      mem[12'h020] <= P1;
    end else if (!bus.sram_csbn) begin
      if (!bus.sram_wsbn) mem[bus.sram_waddr] <= {32'h0, bus.sram_wdata};
      sram_rdata_q <= mem[bus.sram_raddr];
    end
  end
  assign bus.sram_rdata = sram_rdata_q;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [RDATA_W-1:0] got,
                          input logic [RDATA_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    bus.wr_valid  = 1'b0;
    bus.rd0_valid = 1'b0;
    bus.rd1_valid = 1'b0;
  endtask

  logic [5:0] grant_rd1;

  initial begin
    grant_rd1 = 6'b101010;
    // reset with every request asserted
    rst = 1'b1;
    bus.wr_valid = 1'b1; bus.wr_addr = 12'h555; bus.wr_data = WA5;
    bus.rd0_valid = 1'b1; bus.rd0_addr = 12'h010;
    bus.rd1_valid = 1'b1; bus.rd1_addr = 12'h020;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_eq($sformatf("rst%0d_wr_ready", c), bus.wr_ready, 0);
      check_eq($sformatf("rst%0d_rd0_ready", c), bus.rd0_ready, 0);
      check_eq($sformatf("rst%0d_rd1_ready", c), bus.rd1_ready, 0);
      check_eq($sformatf("rst%0d_csbn", c), bus.sram_csbn, 1);
      check_eq($sformatf("rst%0d_wsbn", c), bus.sram_wsbn, 1);
      check_eq($sformatf("rst%0d_resp_v", c), {bus.rd1_resp_valid, bus.rd0_resp_valid}, 0);
      tick();
    end
    @(negedge clk);
    check_eq("rst_waddr", bus.sram_waddr, 0);
    check_eq("rst_raddr", bus.sram_raddr, 0);
    check_eq("rst_wdata", bus.sram_wdata, 0);
    tick();

    // first contended read after reset goes to rd0
    rst = 1'b0;
    bus.wr_valid = 1'b0;
    @(negedge clk);
    check_eq("first_rd0_ready", bus.rd0_ready, 1);
    check_eq("first_rd1_ready", bus.rd1_ready, 0);
    check_eq("first_csbn", bus.sram_csbn, 0);
    check_eq("first_raddr", bus.sram_raddr, 12'h010);
    tick();
    set_idle();
    @(negedge clk);
    check_eq("first_rd0_resp_v", bus.rd0_resp_valid, 1);
    check_eq("first_rd1_resp_v", bus.rd1_resp_valid, 0);
    check_eq("first_rd0_data", bus.rd0_resp_data, P0);
    tick();
    @(negedge clk);
    check_eq("idle_csbn", bus.sram_csbn, 1);
    check_eq("idle_wsbn", bus.sram_wsbn, 1);
    check_eq("idle_resp_v", {bus.rd1_resp_valid, bus.rd0_resp_valid}, 0);
    tick();

    // write-only cycle, then rd1 reads the same address
    bus.wr_valid = 1'b1; bus.wr_addr = 12'h123; bus.wr_data = WA5;
    @(negedge clk);
    check_eq("wr_ready", bus.wr_ready, 1);
    check_eq("wr_wsbn", bus.sram_wsbn, 0);
    check_eq("wr_csbn", bus.sram_csbn, 0);
    check_eq("wr_waddr", bus.sram_waddr, 12'h123);
    check_eq("wr_wdata", bus.sram_wdata, WA5);
    tick();
    bus.wr_valid = 1'b0;
    bus.rd1_valid = 1'b1; bus.rd1_addr = 12'h123;
    @(negedge clk);
    check_eq("wo_no_resp", {bus.rd1_resp_valid, bus.rd0_resp_valid}, 0);
    check_eq("rd1_ready", bus.rd1_ready, 1);
    check_eq("rd1_rd0_ready", bus.rd0_ready, 0);
    tick();
    set_idle();
    @(negedge clk);
    check_eq("rd1_resp_v", bus.rd1_resp_valid, 1);
    check_eq("rd1_rd0_resp_v", bus.rd0_resp_valid, 0);
    check_eq("rd1_data", bus.rd1_resp_data, {32'h0, WA5});
    tick();
    @(negedge clk);
    check_eq("rd1_resp_once", bus.rd1_resp_valid, 0);
    tick();

    // contention: both readers for six cycles, expect strict alternation
    bus.rd0_valid = 1'b1; bus.rd0_addr = 12'h010;
    bus.rd1_valid = 1'b1; bus.rd1_addr = 12'h020;
    for (int k = 0; k < 7; k++) begin
      if (k == 6) set_idle();
      @(negedge clk);
      if (k < 6) begin
        check_eq($sformatf("cont%0d_rd0_ready", k), bus.rd0_ready, !grant_rd1[k]);
        check_eq($sformatf("cont%0d_rd1_ready", k), bus.rd1_ready, grant_rd1[k]);
      end
      if (k > 0) begin
        check_eq($sformatf("cont%0d_rd0_resp_v", k), bus.rd0_resp_valid, !grant_rd1[k-1]);
        check_eq($sformatf("cont%0d_rd1_resp_v", k), bus.rd1_resp_valid, grant_rd1[k-1]);
        check_eq($sformatf("cont%0d_data", k), bus.rd0_resp_data, grant_rd1[k-1] ? P1 : P0);
      end
      tick();
    end

    // read-after-write collision on 0xFFF; rd1 also waiting
    bus.wr_valid = 1'b1; bus.wr_addr = 12'hFFF; bus.wr_data = WD;
    bus.rd0_valid = 1'b1; bus.rd0_addr = 12'hFFF;
    bus.rd1_valid = 1'b1; bus.rd1_addr = 12'h020;
    @(negedge clk);
    check_eq("raw_wsbn", bus.sram_wsbn, 0);
    check_eq("raw_rd1_ready", bus.rd1_ready, 0);
`ifdef SRAM_ARB_RAW_BYPASS_EN
    check_eq("raw_rd0_ready", bus.rd0_ready, 1);
    tick();
    set_idle();
    @(negedge clk);
    check_eq("raw_resp_v", bus.rd0_resp_valid, 1);
    check_eq("raw_data", bus.rd0_resp_data, {32'h0, WD});
    tick();
`else
    check_eq("raw_rd0_ready", bus.rd0_ready, 0);
    tick();
    bus.wr_valid = 1'b0;
    bus.rd1_valid = 1'b0;
    @(negedge clk);
    check_eq("raw_retry_ready", bus.rd0_ready, 1);
    check_eq("raw_stall_no_resp", {bus.rd1_resp_valid, bus.rd0_resp_valid}, 0);
    tick();
    set_idle();
    @(negedge clk);
    check_eq("raw_resp_v", bus.rd0_resp_valid, 1);
    check_eq("raw_data", bus.rd0_resp_data, {32'h0, WD});
    tick();
`endif

    // reset arriving the cycle after a grant
    bus.rd0_valid = 1'b1; bus.rd0_addr = 12'h020;
    @(negedge clk);
    check_eq("mid_grant", bus.rd0_ready, 1);
    tick();
    rst = 1'b1;
    bus.wr_valid = 1'b1; bus.rd1_valid = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_resp_v", bus.rd0_resp_valid, 1);
    check_eq("mid_rst_data", bus.rd0_resp_data, P1);
    check_eq("mid_rst_ready", {bus.wr_ready, bus.rd1_ready, bus.rd0_ready}, 0);
    check_eq("mid_rst_en", {bus.sram_csbn, bus.sram_wsbn}, 2'b11);
    tick();
    @(negedge clk);
    check_eq("mid_rst2_resp_v", {bus.rd1_resp_valid, bus.rd0_resp_valid}, 0);
    check_eq("mid_rst2_ready", {bus.wr_ready, bus.rd1_ready, bus.rd0_ready}, 0);
    tick();
    rst = 1'b0;
    bus.wr_valid = 1'b0;
    bus.rd0_addr = 12'h010; bus.rd1_addr = 12'h020;
    @(negedge clk);
    check_eq("post_rst_resp_v", {bus.rd1_resp_valid, bus.rd0_resp_valid}, 0);
    check_eq("post_rst_rd0_ready", bus.rd0_ready, 1);
    check_eq("post_rst_rd1_ready", bus.rd1_ready, 0);
    tick();
    set_idle();
    @(negedge clk);
    check_eq("post_rst_data", bus.rd0_resp_data, P0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
